// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline control sequencer for a 5-stage MIPS core
//
// Carries decoded ID-stage control through the ID/EX, EX/MEM and MEM/WB
// control registers. It also detects load-use hazards, flushes on a taken
// beq resolved in EX, and produces EX-stage forwarding selects. Saturating
// stall and flush counters are kept for performance debug.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   id_*                  ID-stage register fields and control-unit outputs
//   ex_zero               ALU zero flag of the instruction in EX
//   stall_f, stall_d      hold PC / IF-ID register on a load-use hazard
//   flush_d, pc_src       taken branch: clear IF/ID, select branch target
//   ex_*                  EX-stage controls and destination register
//   fwd_a, fwd_b          EX operand select: 00 regfile, 10 MEM, 01 WB
//   mem_*, wb_*           MEM- and WB-stage controls and destinations
//   stall_cnt, flush_cnt  saturating event counters
module hazard_ctrl #(
  parameter int RA_W   = 5,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_reg_write,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_branch,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic [ALUC_W-1:0] id_alu_control,
  input  logic              ex_zero,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              pc_src,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [ALUC_W-1:0] ex_alu_control,
  output logic [RA_W-1:0]   ex_wr_reg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_write,
  output logic              mem_to_reg_m,
  output logic              mem_reg_write,
  output logic [RA_W-1:0]   mem_wr_reg,
  output logic              wb_reg_write,
  output logic              wb_to_reg,
  output logic [RA_W-1:0]   wb_wr_reg,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // ID/EX control register
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_reg_dst_q, ex_reg_dst_d;
  logic              ex_alu_src_q, ex_alu_src_d;
  logic              ex_branch_q, ex_branch_d;
  logic              ex_mem_write_q, ex_mem_write_d;
  logic              ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic [ALUC_W-1:0] ex_alu_control_q, ex_alu_control_d;
  logic [RA_W-1:0]   ex_rs_q, ex_rs_d;
  logic [RA_W-1:0]   ex_rt_q, ex_rt_d;
  logic [RA_W-1:0]   ex_rd_q, ex_rd_d;

  // EX/MEM and MEM/WB control registers
  logic              mem_write_q, mem_to_reg_q, mem_reg_write_q;
  logic [RA_W-1:0]   mem_wr_reg_q;
  logic              wb_reg_write_q, wb_to_reg_q;
  logic [RA_W-1:0]   wb_wr_reg_q;

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              lw_stall;
  logic              take_branch;
  logic              flush_e;
  logic [RA_W-1:0]   ex_wr_reg_w;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign ex_wr_reg_w = ex_reg_dst_q ? ex_rd_q : ex_rt_q;

  // A load in EX whose destination is read by the ID instruction must
  // wait one cycle; after that the loaded value is available from WB.
  assign lw_stall = ex_mem_to_reg_q & ex_reg_write_q & (ex_wr_reg_w != '0) &
                    ((ex_wr_reg_w == id_rs) | (ex_wr_reg_w == id_rt)) & id_valid;

  assign take_branch = ex_branch_q & ex_zero;

  // The EX instruction is either a load or a branch, never both, so the
  // two bubble sources cannot conflict.
  assign flush_e = lw_stall | take_branch;

  // MEM result is newer than WB, so it wins; $0 is hard-wired and never
  // forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
    if (mem_reg_write_q && (mem_wr_reg_q != '0) && (mem_wr_reg_q == src)) begin
      return 2'b10;
    end else if (wb_reg_write_q && (wb_wr_reg_q != '0) && (wb_wr_reg_q == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // The bubble path never reads id_* so unknown controls from an
  // undecoded op cannot reach the pipeline.
  always_comb begin
    ex_reg_write_d   = 1'b0;
    ex_reg_dst_d     = 1'b0;
    ex_alu_src_d     = 1'b0;
    ex_branch_d      = 1'b0;
    ex_mem_write_d   = 1'b0;
    ex_mem_to_reg_d  = 1'b0;
    ex_alu_control_d = '0;
    ex_rs_d          = '0;
    ex_rt_d          = '0;
    ex_rd_d          = '0;
    if (id_valid && !flush_e) begin
      ex_reg_write_d   = id_reg_write;
      ex_reg_dst_d     = id_reg_dst;
      ex_alu_src_d     = id_alu_src;
      ex_branch_d      = id_branch;
      ex_mem_write_d   = id_mem_write;
      ex_mem_to_reg_d  = id_mem_to_reg;
      ex_alu_control_d = id_alu_control;
      ex_rs_d          = id_rs;
      ex_rt_d          = id_rt;
      ex_rd_d          = id_rd;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lw_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (take_branch && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_reg_write_q   <= 1'b0;
      ex_reg_dst_q     <= 1'b0;
      ex_alu_src_q     <= 1'b0;
      ex_branch_q      <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      ex_mem_to_reg_q  <= 1'b0;
      ex_alu_control_q <= '0;
      ex_rs_q          <= '0;
      ex_rt_q          <= '0;
      ex_rd_q          <= '0;
      mem_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_wr_reg_q     <= '0;
      wb_reg_write_q   <= 1'b0;
      wb_to_reg_q      <= 1'b0;
      wb_wr_reg_q      <= '0;
      stall_cnt_q      <= '0;
      flush_cnt_q      <= '0;
    end else begin
      ex_reg_write_q   <= ex_reg_write_d;
      ex_reg_dst_q     <= ex_reg_dst_d;
      ex_alu_src_q     <= ex_alu_src_d;
      ex_branch_q      <= ex_branch_d;
      ex_mem_write_q   <= ex_mem_write_d;
      ex_mem_to_reg_q  <= ex_mem_to_reg_d;
      ex_alu_control_q <= ex_alu_control_d;
      ex_rs_q          <= ex_rs_d;
      ex_rt_q          <= ex_rt_d;
      ex_rd_q          <= ex_rd_d;
      mem_write_q      <= ex_mem_write_q;
      mem_to_reg_q     <= ex_mem_to_reg_q;
      mem_reg_write_q  <= ex_reg_write_q;
      mem_wr_reg_q     <= ex_wr_reg_w;
      wb_reg_write_q   <= mem_reg_write_q;
      wb_to_reg_q      <= mem_to_reg_q;
      wb_wr_reg_q      <= mem_wr_reg_q;
      stall_cnt_q      <= stall_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
    end
  end

  assign stall_f        = lw_stall;
  assign stall_d        = lw_stall;
  assign pc_src         = take_branch;
  assign flush_d        = take_branch;
  assign ex_alu_src     = ex_alu_src_q;
  assign ex_reg_dst     = ex_reg_dst_q;
  assign ex_alu_control = ex_alu_control_q;
  assign ex_wr_reg      = ex_wr_reg_w;
  assign fwd_a          = fwd_sel(ex_rs_q);
  assign fwd_b          = fwd_sel(ex_rt_q);
  assign mem_write      = mem_write_q;
  assign mem_to_reg_m   = mem_to_reg_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_wr_reg     = mem_wr_reg_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign wb_to_reg      = wb_to_reg_q;
  assign wb_wr_reg      = wb_wr_reg_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic id_reg_write, id_reg_dst, id_alu_src, id_branch, id_mem_write, id_mem_to_reg;
  logic [2:0] id_alu_control;
  logic ex_zero;

  logic stall_f, stall_d, flush_d, pc_src, ex_alu_src, ex_reg_dst;
  logic [2:0] ex_alu_control;
  logic [4:0] ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic [1:0] fwd_a, fwd_b;
  logic mem_write, mem_to_reg_m, mem_reg_write, wb_reg_write, wb_to_reg;
  logic [15:0] stall_cnt, flush_cnt;

  // narrow-counter instance sharing the same stimulus, for saturation
  logic s_stall_f, s_stall_d, s_flush_d, s_pc_src, s_ex_alu_src, s_ex_reg_dst;
  logic [2:0] s_ex_alu_control;
  logic [4:0] s_ex_wr_reg, s_mem_wr_reg, s_wb_wr_reg;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic s_mem_write, s_mem_to_reg_m, s_mem_reg_write, s_wb_reg_write, s_wb_to_reg;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(5), .ALUC_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_control(id_alu_control), .ex_zero(ex_zero),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .pc_src(pc_src),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_alu_control(ex_alu_control),
    .ex_wr_reg(ex_wr_reg), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_write(mem_write), .mem_to_reg_m(mem_to_reg_m), .mem_reg_write(mem_reg_write),
    .mem_wr_reg(mem_wr_reg), .wb_reg_write(wb_reg_write), .wb_to_reg(wb_to_reg),
    .wb_wr_reg(wb_wr_reg), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.RA_W(5), .ALUC_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_control(id_alu_control), .ex_zero(ex_zero),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d), .pc_src(s_pc_src),
    .ex_alu_src(s_ex_alu_src), .ex_reg_dst(s_ex_reg_dst), .ex_alu_control(s_ex_alu_control),
    .ex_wr_reg(s_ex_wr_reg), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .mem_write(s_mem_write), .mem_to_reg_m(s_mem_to_reg_m), .mem_reg_write(s_mem_reg_write),
    .mem_wr_reg(s_mem_wr_reg), .wb_reg_write(s_wb_reg_write), .wb_to_reg(s_wb_to_reg),
    .wb_wr_reg(s_wb_wr_reg), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct packed {
    logic v; logic [4:0] rs, rt, rd;
    logic rw, rdst, asrc, br, mw, m2r;
    logic [2:0] aluc; logic zero;
  } in_t;

  typedef struct packed {
    logic st_f, st_d, fl, pc;
    logic [1:0] fa, fb;
    logic ex_as, ex_rd; logic [2:0] ex_alu; logic [4:0] ex_wr;
    logic m_w, m_m2r, m_rw; logic [4:0] m_wr;
    logic w_rw, w_m2r; logic [4:0] w_wr;
    logic [15:0] sc, fc;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  int n_vec = 0;
  int n_bad = 0;

  function automatic in_t nop();
    in_t x = '0;
    return x;
  endfunction

  function automatic in_t nopx();
    in_t x = 'x;
    x.v = 1'b0;
    x.zero = 1'b0;
    return x;
  endfunction

  function automatic in_t rtype(input logic [4:0] rd, rs, rt, input logic [2:0] aluc);
    in_t x = '0;
    x.v = 1'b1; x.rd = rd; x.rs = rs; x.rt = rt;
    x.rw = 1'b1; x.rdst = 1'b1; x.aluc = aluc;
    return x;
  endfunction

  function automatic in_t lw(input logic [4:0] rt, rs);
    in_t x = '0;
    x.v = 1'b1; x.rt = rt; x.rs = rs;
    x.rw = 1'b1; x.asrc = 1'b1; x.m2r = 1'b1; x.aluc = 3'b010;
    return x;
  endfunction

  function automatic in_t sw(input logic [4:0] rt, rs);
    in_t x = '0;
    x.v = 1'b1; x.rt = rt; x.rs = rs;
    x.mw = 1'b1; x.asrc = 1'b1; x.aluc = 3'b010;
    return x;
  endfunction

  function automatic in_t beq(input logic [4:0] rs, rt);
    in_t x = '0;
    x.v = 1'b1; x.rs = rs; x.rt = rt;
    x.br = 1'b1; x.aluc = 3'b110;
    return x;
  endfunction

  function automatic out_t mk_o(
      input logic st, fl, input logic [1:0] fa, fb,
      input logic as, rd, input logic [2:0] alu, input logic [4:0] ewr,
      input logic mw, mm2r, mrw, input logic [4:0] mwr,
      input logic wrw, wm2r, input logic [4:0] wwr,
      input logic [15:0] sc, fc);
    out_t o;
    o.st_f = st; o.st_d = st; o.fl = fl; o.pc = fl;
    o.fa = fa; o.fb = fb;
    o.ex_as = as; o.ex_rd = rd; o.ex_alu = alu; o.ex_wr = ewr;
    o.m_w = mw; o.m_m2r = mm2r; o.m_rw = mrw; o.m_wr = mwr;
    o.w_rw = wrw; o.w_m2r = wm2r; o.w_wr = wwr;
    o.sc = sc; o.fc = fc;
    return o;
  endfunction

  function automatic out_t actual();
    return {stall_f, stall_d, flush_d, pc_src, fwd_a, fwd_b,
            ex_alu_src, ex_reg_dst, ex_alu_control, ex_wr_reg,
            mem_write, mem_to_reg_m, mem_reg_write, mem_wr_reg,
            wb_reg_write, wb_to_reg, wb_wr_reg, stall_cnt, flush_cnt};
  endfunction

  task automatic drive(input in_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    id_reg_write = x.rw; id_reg_dst = x.rdst; id_alu_src = x.asrc;
    id_branch = x.br; id_mem_write = x.mw; id_mem_to_reg = x.m2r;
    id_alu_control = x.aluc; ex_zero = x.zero;
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t act = actual();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input in_t x);
    drive(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stream: fwd MEM/WB, load-use, taken/untaken beq, $0 writes, bubbles, sw
    vecs[0]  = '{rtype(3,1,2,3'b010), mk_o(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0)};
    vecs[1]  = '{rtype(4,3,5,3'b110), mk_o(0,0,0,0, 0,1,2,3, 0,0,0,0, 0,0,0, 0,0)};
    vecs[2]  = '{rtype(6,3,7,3'b000), mk_o(0,0,2,0, 0,1,6,4, 0,0,1,3, 0,0,0, 0,0)};
    vecs[3]  = '{nop(),               mk_o(0,0,1,0, 0,1,0,6, 0,0,1,4, 1,0,3, 0,0)};
    vecs[4]  = '{lw(2,1),             mk_o(0,0,0,0, 0,0,0,0, 0,0,1,6, 1,0,4, 0,0)};
    vecs[5]  = '{rtype(4,2,3,3'b010), mk_o(1,0,0,0, 1,0,2,2, 0,0,0,0, 1,0,6, 0,0)};
    vecs[6]  = '{rtype(4,2,3,3'b010), mk_o(0,0,0,0, 0,0,0,0, 0,1,1,2, 0,0,0, 1,0)};
    vecs[7]  = '{beq(1,1),            mk_o(0,0,1,0, 0,1,2,4, 0,0,0,0, 1,1,2, 1,0)};
    vecs[8]  = '{rtype(9,8,8,3'b010), mk_o(0,1,0,0, 0,0,6,1, 0,0,1,4, 0,0,0, 1,0)};
    vecs[9]  = '{beq(1,2),            mk_o(0,0,0,0, 0,0,0,0, 0,0,0,1, 1,0,4, 1,1)};
    vecs[10] = '{rtype(0,1,2,3'b010), mk_o(0,0,0,0, 0,0,6,2, 0,0,0,0, 0,0,1, 1,1)};
    vecs[11] = '{rtype(5,0,0,3'b110), mk_o(0,0,0,0, 0,1,2,0, 0,0,0,2, 0,0,0, 1,1)};
    vecs[12] = '{lw(0,1),             mk_o(0,0,0,0, 0,1,6,5, 0,0,1,0, 0,0,2, 1,1)};
    vecs[13] = '{rtype(7,0,1,3'b010), mk_o(0,0,0,0, 1,0,2,0, 0,0,1,5, 1,0,0, 1,1)};
    vecs[14] = '{nopx(),              mk_o(0,0,0,0, 0,1,2,7, 0,1,1,0, 1,0,5, 1,1)};
    vecs[15] = '{nopx(),              mk_o(0,0,0,0, 0,0,0,0, 0,0,1,7, 1,1,0, 1,1)};
    vecs[16] = '{nopx(),              mk_o(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,7, 1,1)};
    vecs[17] = '{nop(),               mk_o(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,1)};
    vecs[18] = '{lw(2,1),             mk_o(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,1)};
    vecs[19] = '{rtype(4,2,3,3'b010), mk_o(0,0,0,0, 1,0,2,2, 0,0,0,0, 0,0,0, 1,1)};
    vecs[20] = '{nop(),               mk_o(0,0,0,0, 0,0,0,0, 0,1,1,2, 0,0,0, 1,1)};
    vecs[21] = '{sw(2,1),             mk_o(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,1,2, 1,1)};
    vecs[22] = '{nop(),               mk_o(0,0,0,0, 1,0,2,2, 0,0,0,0, 0,0,0, 1,1)};
    vecs[23] = '{nop(),               mk_o(0,0,0,0, 0,0,0,0, 1,0,0,2, 0,0,0, 1,1)};
    vecs[24] = '{nop(),               mk_o(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,2, 1,1)};
    vecs[8].i.zero  = 1'b1;
    vecs[9].i.zero  = 1'b1;
    vecs[16].i.zero = 1'b1;
    vecs[19].i.v    = 1'b0;

    reset = 1'b1;
    drive(nop());
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].i);
      @(negedge clk);
      check_out($sformatf("vec%0d", k), vecs[k].o);
      @(posedge clk);
      #1;
    end

    // reset held two cycles with a load-use pair pending
    step(lw(2,1));
    drive(rtype(4,2,3,3'b010));
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_out("reset_hold", '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(nop());
    @(negedge clk);
    check_out("after_reset", '0);
    @(posedge clk);
    #1;

    // four load-use stalls: wide counter reaches 4, narrow one saturates
    for (int n = 0; n < 4; n++) begin
      step(lw(2,1));
      step(rtype(4,2,3,3'b010));
      step(rtype(4,2,3,3'b010));
    end
    drive(nop());
    @(negedge clk);
    check_val("stall_cnt_4", stall_cnt, 16'd4);
    check_val("stall_sat", {14'd0, s_stall_cnt}, 16'd3);
    check_val("flush_cnt_0", flush_cnt, 16'd0);
    @(posedge clk);
    #1;

    // four taken branches
    for (int n = 0; n < 4; n++) begin
      in_t z;
      step(beq(1,1));
      z = nop();
      z.zero = 1'b1;
      step(z);
      step(nop());
    end
    drive(nop());
    @(negedge clk);
    check_val("flush_cnt_4", flush_cnt, 16'd4);
    check_val("flush_sat", {14'd0, s_flush_cnt}, 16'd3);
    check_val("stall_sat_hold", {14'd0, s_stall_cnt}, 16'd3);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control sequencer for the 5-stage MIPS core: takes decoded ID-stage control from the control unit and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and stalls fetch/decode, flushes on taken beq resolved in EX, and generates EX-stage forwarding selects.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- RA_W, 5, register address width
- ALUC_W, 3, alu_control width
- CNT_W, 16, width of stall/flush counters

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID instruction valid; 0 injects a bubble
- id_rs, id_rt, id_rd  in  RA_W each  ID register fields
- id_reg_write, id_reg_dst, id_alu_src, id_branch, id_mem_write, id_mem_to_reg  in  1 each  control-unit outputs
- id_alu_control  in  ALUC_W  control-unit ALU select
- ex_zero  in  1  ALU zero flag of the EX instruction
- stall_f, stall_d  out  1 each  hold PC / IF-ID register
- flush_d  out  1  clear IF/ID register
- pc_src  out  1  1 = take branch target
- ex_alu_src, ex_reg_dst  out  1 each  EX controls
- ex_alu_control  out  ALUC_W  EX ALU select
- ex_wr_reg  out  RA_W  EX destination (rd if ex_reg_dst, else rt)
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 MEM result, 01 WB result
- mem_write, mem_to_reg_m, mem_reg_write  out  1 each  MEM controls
- mem_wr_reg  out  RA_W  MEM destination
- wb_reg_write, wb_to_reg  out  1 each  WB controls
- wb_wr_reg  out  RA_W  WB destination
- stall_cnt, flush_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (sync, high): all EX/MEM/WB control registers, register addresses and counters go to 0. All outputs are 0 in the cycle after reset is sampled. Reset takes effect regardless of stall or flush.
- ID/EX register: loads the id_* values on each edge.
  - Loads a bubble (all controls 0, rs/rt/rd = 0) if flush_e = 1 or id_valid = 0.
  - Captured id_alu_control is forced to 0 in a bubble. X values from an undecoded op never propagate.
- EX/MEM and MEM/WB registers: always advance. No stall in those stages.
- mem_wr_reg and wb_wr_reg: ex_wr_reg delayed by 1 and 2 cycles respectively.
- Load-use hazard (combinational):
  - lw_stall = ex_mem_to_reg & ex_reg_write & (ex_wr_reg != 0) & ((ex_wr_reg == id_rs) | (ex_wr_reg == id_rt)) & id_valid.
  - stall_f = stall_d = lw_stall.
  - Produces exactly one bubble; the dependent instruction then receives forwarding from WB.
- Branch (combinational):
  - pc_src = ex_branch & ex_zero.
  - flush_d = pc_src.
  - flush_e (internal) = lw_stall | pc_src.
  - Taken-branch penalty is 2 cycles.
  - lw_stall and pc_src are mutually exclusive, because the EX instruction is either lw or beq. No priority logic is needed beyond the OR.
- Forwarding, per operand, with fwd_a using ex_rs and fwd_b using ex_rt (combinational):
  - 10 if mem_reg_write & mem_wr_reg != 0 & mem_wr_reg == src.
  - Else 01 if wb_reg_write & wb_wr_reg != 0 & wb_wr_reg == src.
  - Else 00.
  - MEM has priority over WB. $0 is never forwarded.
- Counters:
  - stall_cnt increments each cycle lw_stall = 1.
  - flush_cnt increments each cycle pc_src = 1.
  - Both saturate at all-ones and do not wrap.
- Same-cycle regfile write/read of the same register is resolved by the register file's write-first behaviour, not by this block.

Test Plan:
- Reset held 2 cycles mid-stream with pending lw in EX → all outputs 0 after the reset edge; no stall, counters 0.
- add $3,$1,$2 then sub $4,$3,$5 → sub in EX: fwd_a = 10. Following and $6,$3,$7 in EX: fwd_a = 01. fwd_b = 00 throughout.
- lw $2,0($1) then add $4,$2,$3 → exactly 1 cycle stall_f = stall_d = 1, bubble in EX (all controls 0), then add in EX with fwd_a = 01; stall_cnt = 1.
- beq in EX with ex_zero = 1 → pc_src = flush_d = 1 for 1 cycle. Next-cycle EX and MEM-bound controls are bubbles; flush_cnt = 1. With ex_zero = 0: no flush.
- Writes to $0 (add $0,$1,$2 followed by a reader of $0) → fwd_a = 00. A lw writing $0 followed by a reader → no stall.
- id_valid = 0 for 3 cycles, and an undecoded op (X controls) with id_valid = 0 → EX/MEM/WB controls are 0, with no X on any output. Force stall_cnt to 0xFFFF and trigger lw_stall → it stays 0xFFFF.
